cmn_rr_arb_bin: RTL and testbench
=================================

# cmn_rr_arb_bin

Registered round-robin arbiter for the L1D request path. Picks one of `REQ_NUM` requesters each cycle and presents the winner as a binary index with a valid/ready handshake. The downstream stage decodes that index to a one-hot select for the shared datapath mux. The grant is held stable until the consumer accepts it, and priority rotates past each accepted winner.

## Interface
- `IDX_WIDTH`, default 3: width of the binary grant index.
- `REQ_NUM`, default `2**IDX_WIDTH`: number of requesters. Derived; must not be overridden.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous active-low reset. Asserts immediately, releases synchronously to `clk`.
- `req`  in  `REQ_NUM`  per-requester request level; bit i = requester i.
- `arb_clr`  in  1  synchronous clear: drops any pending grant and resets priority.
- `gnt_vld`  out  1  grant register holds a valid winner.
- `gnt_idx`  out  `IDX_WIDTH`  binary index of the granted requester.
- `gnt_rdy`  in  1  consumer accepts the grant this cycle when high together with `gnt_vld`.

## Operation
- State registers:
  - `ptr` (`IDX_WIDTH`), the highest-priority index.
  - `gnt_vld` (1).
  - `gnt_idx` (`IDX_WIDTH`).
- Two states, encoded by `gnt_vld`:
  - EMPTY (`gnt_vld`=0).
  - HELD (`gnt_vld`=1).
- Combinational pick: scan `req` starting at `ptr`, ascending, wrapping modulo `REQ_NUM`. The winner is the first set bit. `pick_vld` = `|req`.
- Load enable `ld` = `!gnt_vld || gnt_rdy`, i.e. the register is empty or being drained this cycle.
- EMPTY:
  - if `pick_vld`: load `gnt_idx`=pick, go to HELD;
  - else stay EMPTY.
- HELD, `gnt_rdy`=0: hold `gnt_idx` unchanged. `req` is ignored; a dropped request does not revoke the grant.
- HELD, `gnt_rdy`=1 (accept):
  - `ptr` <= `gnt_idx`+1, truncated to `IDX_WIDTH` so it wraps naturally.
  - In the same cycle, if `pick_vld`, load the new pick and stay HELD (back-to-back, one grant per cycle).
  - Otherwise go to EMPTY.
- The same-cycle pick uses the pre-update `ptr`, but the just-accepted index must not win:
  - the candidate search starts at `gnt_idx`+1 when accepting, and at `ptr` otherwise;
  - the accepted index is still eligible if it is the only requester.
- `ptr` changes only on accept or clear. It never changes on load alone.
- `arb_clr`=1 overrides everything else: `gnt_vld`<=0, `ptr`<=0, `gnt_idx`<=0. A grant presented in that cycle is discarded even if `gnt_rdy`=1.
- `gnt_idx` retains its last value in EMPTY; consumers qualify it with `gnt_vld`.

## Timing
- Reset values: `gnt_vld`=0, `gnt_idx`=0, `ptr`=0.
- Latency: `req` sampled at edge N gives `gnt_vld`/`gnt_idx` at N+1. There is no combinational path from `req` or `gnt_rdy` to any output.
- Throughput: one accepted grant per cycle when `gnt_rdy` is held high and requests are present.
- While `gnt_vld`=1 and `gnt_rdy`=0, `gnt_idx` is stable for every cycle.
- Asynchronous reset mid-HELD clears immediately. The pending grant is lost and no accept is recorded.
- `gnt_rdy` while EMPTY has no effect.

## Test plan
- Reset: assert `rst_n`=0 with `req`=0xFF -> `gnt_vld`=0 and `gnt_idx`=0 throughout reset. After release, the first grant is idx 0 one cycle later.
- Full rotation: `req`=0xFF and `gnt_rdy`=1 held -> `gnt_idx` = 0,1,2,…,7,0,1 on consecutive cycles with `gnt_vld`=1 continuously.
- Sparse fairness: `req`=0x81 and `gnt_rdy`=1 -> grants alternate 0,7,0,7. Single requester `req`=0x10 -> idx 4 granted every cycle.
- Stall and hold: `req`=0x04, `gnt_rdy`=0 for 3 cycles, then `req`=0x08 with `gnt_rdy`=0 -> `gnt_idx`=2 stable all cycles. Then `gnt_rdy`=1 -> accept of 2 and next cycle `gnt_idx`=3.
- Wrap: after accepting idx 6 (`ptr`=7), `req`=0x41 -> next grant is idx 0, not 6. Then `ptr`=1.
- Clear and async reset mid-stall:
  - HELD idx 5 with `gnt_rdy`=1 and `arb_clr`=1 -> next cycle `gnt_vld`=0, `ptr`=0, no accept recorded.
  - Repeat, pulling `rst_n` low mid-cycle -> `gnt_vld` drops before the next edge.

Source files
------------

// File: rtl/cmn_rr_arb_bin.sv
// Registered round-robin arbiter with binary grant index.
// Grant is held until accepted; priority rotates past each accepted winner.
module cmn_rr_arb_bin #(
  parameter  int IDX_WIDTH = 3,
  localparam int REQ_NUM   = 2**IDX_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REQ_NUM-1:0]   req,
  input  logic                 arb_clr,
  output logic                 gnt_vld,
  output logic [IDX_WIDTH-1:0] gnt_idx,
  input  logic                 gnt_rdy
);

  typedef enum logic {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [IDX_WIDTH-1:0] r_idx;
  logic [IDX_WIDTH-1:0] r_ptr;
  logic [IDX_WIDTH-1:0] w_idx_nxt;
  logic [IDX_WIDTH-1:0] w_ptr_nxt;
  logic [IDX_WIDTH-1:0] w_start;
  logic [IDX_WIDTH-1:0] w_cand;
  logic [IDX_WIDTH-1:0] w_pick;
  logic                 w_found;
  logic                 w_pick_vld;
  logic                 w_acc;

  assign w_acc      = (r_state == HELD) && gnt_rdy;
  assign w_pick_vld = |req;

  // On accept the search skips the index just drained.
  always_comb begin
    w_start = w_acc ? r_idx + 1'b1 : r_ptr;
    w_pick  = w_start;
    w_found = 1'b0;
    w_cand  = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      w_cand = w_start + IDX_WIDTH'(i);
      if (!w_found && req[w_cand]) begin
        w_pick  = w_cand;
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_ptr_nxt   = r_ptr;
    if (arb_clr) begin
      w_state_nxt = EMPTY;
      w_idx_nxt   = '0;
      w_ptr_nxt   = '0;
    end else begin
      if (w_acc) w_ptr_nxt = r_idx + 1'b1;
      unique case (r_state)
        EMPTY: begin
          if (w_pick_vld) begin
            w_state_nxt = HELD;
            w_idx_nxt   = w_pick;
          end
        end
        HELD: begin
          if (gnt_rdy) begin
            if (w_pick_vld) w_idx_nxt = w_pick;
            else            w_state_nxt = EMPTY;
          end
        end
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_idx   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  assign gnt_vld = (r_state == HELD);
  assign gnt_idx = r_idx;

endmodule

// File: tb/tb_cmn_rr_arb_bin.sv
// Bench for cmn_rr_arb_bin: behavioural model compared every cycle
// plus directed vectors with literal expectations.
module tb_cmn_rr_arb_bin;

  localparam int W = 3;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic         arb_clr;
  logic         gnt_vld;
  logic [W-1:0] gnt_idx;
  logic         gnt_rdy;

  int n_chk = 0;
  int n_err = 0;

  int m_vld;
  int m_idx;
  int m_ptr;

  cmn_rr_arb_bin #(.IDX_WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .arb_clr (arb_clr),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx),
    .gnt_rdy (gnt_rdy)
  );

  always #5 clk = ~clk;

  function automatic int first_from(logic [N-1:0] r, int st);
    for (int k = 0; k < N; k++) begin
      if (r[(st + k) % N]) return (st + k) % N;
    end
    return -1;
  endfunction

  function automatic int search_start(int vld, int idx, int ptr, logic rdy);
    return (vld != 0 && rdy) ? (idx + 1) % N : ptr;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vld <= 0;
      m_idx <= 0;
      m_ptr <= 0;
    end else if (arb_clr) begin
      m_vld <= 0;
      m_idx <= 0;
      m_ptr <= 0;
    end else begin
      if (m_vld != 0 && gnt_rdy) m_ptr <= (m_idx + 1) % N;
      if (m_vld == 0 || gnt_rdy) begin
        m_vld <= (req != '0) ? 1 : 0;
        if (req != '0)
          m_idx <= first_from(req, search_start(m_vld, m_idx, m_ptr, gnt_rdy));
      end
    end
  end

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_vld", int'(gnt_vld), m_vld);
    chk("model_idx", int'(gnt_idx), m_idx);
  end

  task automatic cyc(logic [N-1:0] r, logic rdy, logic clr);
    req     = r;
    gnt_rdy = rdy;
    arb_clr = clr;
    @(posedge clk);
    #2;
  endtask

  task automatic lit(string name, int vld, int idx);
    chk({name, "_vld"}, int'(gnt_vld), vld);
    if (vld != 0) chk({name, "_idx"}, int'(gnt_idx), idx);
  endtask

  initial begin
    rst_n   = 1'b0;
    req     = 8'hFF;
    gnt_rdy = 1'b0;
    arb_clr = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #2;
      chk("rst_vld", int'(gnt_vld), 0);
      chk("rst_idx", int'(gnt_idx), 0);
    end
    rst_n = 1'b1;
    cyc(8'hFF, 1'b0, 1'b0);
    lit("first", 1, 0);

    for (int k = 0; k < 10; k++) begin
      cyc(8'hFF, 1'b1, 1'b0);
      lit("rot", 1, (k + 1) % 8);
    end

    for (int k = 0; k < 4; k++) begin
      cyc(8'h81, 1'b1, 1'b0);
      lit("sparse", 1, (k % 2 == 0) ? 7 : 0);
    end
    for (int k = 0; k < 3; k++) begin
      cyc(8'h10, 1'b1, 1'b0);
      lit("single", 1, 4);
    end

    cyc(8'h00, 1'b0, 1'b1);
    lit("clr0", 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(8'h04, 1'b0, 1'b0);
      lit("stall", 1, 2);
    end
    for (int k = 0; k < 2; k++) begin
      cyc(8'h08, 1'b0, 1'b0);
      lit("hold", 1, 2);
    end
    cyc(8'h08, 1'b1, 1'b0);
    lit("after_stall", 1, 3);
    cyc(8'h00, 1'b1, 1'b0);
    lit("drain", 0, 0);
    chk("drain_idx_kept", int'(gnt_idx), 3);

    cyc(8'h40, 1'b0, 1'b0);
    lit("load6", 1, 6);
    cyc(8'h41, 1'b1, 1'b0);
    lit("wrap", 1, 0);
    cyc(8'h41, 1'b1, 1'b0);
    lit("wrap_ptr1", 1, 6);
    cyc(8'h40, 1'b1, 1'b0);
    lit("only_req", 1, 6);
    cyc(8'h00, 1'b1, 1'b0);
    lit("drain2", 0, 0);

    cyc(8'h20, 1'b0, 1'b0);
    lit("held5", 1, 5);
    cyc(8'h20, 1'b1, 1'b1);
    lit("clr", 0, 0);
    chk("clr_idx", int'(gnt_idx), 0);
    cyc(8'h60, 1'b0, 1'b0);
    lit("clr_ptr0", 1, 5);
    cyc(8'h00, 1'b1, 1'b0);
    lit("drain3", 0, 0);

    cyc(8'h20, 1'b0, 1'b0);
    lit("held5b", 1, 5);
    req     = 8'h60;
    gnt_rdy = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_vld", int'(gnt_vld), 0);
    chk("async_idx", int'(gnt_idx), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    cyc(8'h60, 1'b0, 1'b0);
    lit("post_rst", 1, 5);

    cyc(8'h00, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
